// File: rtl/mul_result_stage.sv
// Result stage behind the 3-bit sign-magnitude multiplier. A small FIFO holds raw
// products, and the head entry is presented as two's complement, BCD and flags.
module mul_result_stage #(
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               P4,
    input  logic               P3,
    input  logic               P2,
    input  logic               P1,
    input  logic               P0,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         res_tc,
    output logic               res_sign,
    output logic [3:0]         res_tens,
    output logic [3:0]         res_ones,
    output logic               ZF,
    output logic               EF,
    output logic               OF,
    output logic               ERR,
    output logic [COUNT_W-1:0] res_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]        PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic [4:0]         r_mem [DEPTH];

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic [4:0] w_head;
    logic [3:0] w_mag;

    // Extra wrap bit tells full (same index, different lap) from empty.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && !w_full;
    assign w_pop     = out_valid && out_ready;
    assign res_count = r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_count  <= r_count + CNT_ONE;
            end
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are
    // live, and outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {P4, P3, P2, P1, P0};
        end
    end

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];
    assign w_mag  = w_head[3:0];

    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        res_tc   = 5'd0;
        res_sign = 1'b0;
        res_tens = 4'd0;
        res_ones = 4'd0;
        ZF       = 1'b0;
        EF       = 1'b0;
        OF       = 1'b0;
        ERR      = 1'b0;
        if (out_valid) begin
            res_sign = w_head[4] && (w_mag != 4'd0);
            res_tc   = w_head[4] ? (5'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
            res_tens = (w_mag >= 4'd10) ? 4'd1 : 4'd0;
            res_ones = (w_mag >= 4'd10) ? (w_mag - 4'd10) : w_mag;
            ZF       = (w_mag == 4'd0);
            EF       = ~w_mag[0];
            OF       = w_mag[0];
            ERR      = (w_mag > 4'd9);
        end
    end

endmodule
